// File: rtl/pipeline_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl_pkg
//   Shared definitions for the pipeline stall controller:
//   - stall bus width and per-stage bit positions (PC .. WB)
//   - the four legal stall patterns (contiguous runs of ones from bit 0)
//   - divide sequencer state encoding
// -----------------------------------------------------------------------------
package pipeline_stall_ctrl_pkg;

  localparam int unsigned STALL_W = 6;

  typedef logic [STALL_W-1:0] stall_bus_t;

  // Bit positions within the stall bus.
  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  // Stalling a stage also stalls every stage below it, so each pattern is
  // "all ones from PC up to and including the requesting stage".
  function automatic stall_bus_t stall_upto(input int unsigned top_stage);
    stall_bus_t v;
    v = '0;
    for (int unsigned i = 0; i < STALL_W; i++) begin
      if (i <= top_stage) v[i] = 1'b1;
    end
    return v;
  endfunction

  localparam stall_bus_t STALL_NONE     = '0;
  localparam stall_bus_t STALL_LOAD_USE = stall_upto(STALL_ID);   // 6'b000111
  localparam stall_bus_t STALL_DIV      = stall_upto(STALL_EX);   // 6'b001111
  localparam stall_bus_t STALL_MEM_WAIT = stall_upto(STALL_MEM);  // 6'b011111

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
//   Sequences the iterative HI/LO divide in EX.
//   IDLE -> BUSY on div_start (counter loaded with DIV_CYCLES-1),
//   BUSY counts down to 0 and moves to DONE, DONE waits for MEM to stop
//   stalling before returning to IDLE.
//
// Ports
//   clk        in   pipeline clock
//   rst        in   asynchronous active-low reset
//   div_start  in   EX holds a DIV/DIVU (only looked at in IDLE)
//   mem_stall  in   MEM stage is stalled this cycle (stall bit 4)
//   div_busy   out  divide iterating
//   div_done   out  result valid, EX latches HI/LO
//   div_hold   out  divide needs EX (and below) stalled this cycle
// -----------------------------------------------------------------------------
module div_sequencer
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic div_start,
  input  logic mem_stall,
  output logic div_busy,
  output logic div_done,
  output logic div_hold
);

  localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets its default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (div_start) begin
          state_d = DIV_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      DIV_BUSY: begin
        // Counts regardless of MEM stalls; only DONE waits for MEM.
        if (cnt_q == '0) state_d = DIV_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DIV_DONE: begin
        if (!mem_stall) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  assign div_busy = (state_q == DIV_BUSY);
  assign div_done = (state_q == DIV_DONE);

  // The start cycle stalls combinationally so the DIV does not leave EX
  // before the sequencer has registered it.
  assign div_hold = ((state_q == DIV_IDLE) && div_start)
                  || div_busy
                  || (div_done && mem_stall);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Central stall controller for the five-stage pipeline. Merges the MEM
//   wait, the divide sequencer and the ID load-use request into a single
//   priority-ordered stall vector, flags MEM wait timeouts and counts stalled
//   cycles.
//
// Ports
//   clk           in   pipeline clock, rising edge
//   rst           in   asynchronous active-low reset
//   stall_req_id  in   load-use hazard detected in ID
//   div_start     in   EX holds a DIV/DIVU
//   mem_req       in   MEM stage has an outstanding load/store
//   mem_ready     in   data memory completes this cycle
//   stall         out  per-stage stall: 0=PC 1=IF 2=ID 3=EX 4=MEM 5=WB
//   div_busy      out  divide in progress
//   div_done      out  divide result valid this cycle
//   mem_timeout   out  sticky MEM wait timeout flag
//   stall_count   out  cycles with stall[PC] high, wrapping
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_req_id,
  input  logic                 div_start,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic [STALL_W-1:0]   stall,
  output logic                 div_busy,
  output logic                 div_done,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic              mem_wait;
  logic              mem_stall;
  logic              div_hold;
  logic [WAIT_W-1:0] wait_cnt_q;

  assign mem_wait = mem_req && !mem_ready;

  // Equivalent to stall[STALL_MEM]; taken from the source rather than the
  // merged vector so the sequencer does not loop back through the merge.
  assign mem_stall = rst && mem_wait;

  div_sequencer #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_sequencer (
    .clk       (clk),
    .rst       (rst),
    .div_start (div_start),
    .mem_stall (mem_stall),
    .div_busy  (div_busy),
    .div_done  (div_done),
    .div_hold  (div_hold)
  );

  // Highest-priority source wins; reset forces no stall.
  always_comb begin
    stall = STALL_NONE;
    if (!rst)              stall = STALL_NONE;
    else if (mem_wait)     stall = STALL_MEM_WAIT;
    else if (div_hold)     stall = STALL_DIV;
    else if (stall_req_id) stall = STALL_LOAD_USE;
  end

  // Consecutive MEM wait cycles, saturating; the flag sets on the edge that
  // closes the MEM_TIMEOUT-th wait cycle and stays until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q  <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (!mem_wait)                 wait_cnt_q <= '0;
      else if (wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_cnt_q + 1'b1;

      if (mem_wait && (wait_cnt_q == WAIT_LAST)) mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 stall_count <= '0;
    else if (stall[STALL_PC]) stall_count <= stall_count + 1'b1;
  end

endmodule
